// File: rtl/ddr3_rd_stream_pkg.sv
// Shared constants and state encoding for the DDR3 read-side stream pacer.
package ddr3_rd_pkg;

  localparam int unsigned SKID_DEPTH = 4;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/ddr3_rd_stream_if.sv
// Valid/ready pixel stream with frame markers, as seen by the display pipeline.
interface ddr3_rd_stream_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output m_data, m_valid, m_sof, m_eol, m_eof,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_sof, m_eol, m_eof,
    output m_ready
  );

endinterface

// File: rtl/ddr3_rd_stream_skid.sv
// Small synchronous FIFO that absorbs the read FIFO's latency; the head entry
// drives the stream outputs directly from registers.
module ddr3_rd_skid
  import ddr3_rd_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     din,
  input  logic                  pop,
  output logic [DATA_W-1:0]     dout,
  output logic [SKID_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ddr3_rd_stream.sv
// Read-side pacer: pops the DDR3 read FIFO and emits one H_PIXELS x V_LINES
// frame per rd_start as a marked valid/ready stream.
module ddr3_rd_stream
  import ddr3_rd_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int H_PIXELS = 1024,
  parameter int V_LINES  = 768
) (
  input  logic                  rd_clk,
  input  logic                  rd_clk_sync_rst,
  input  logic                  rd_start,
  input  logic                  rfifo_empty,
  input  logic [DATA_W-1:0]     rddata,
  output logic                  rd_req,
  ddr3_rd_stream_if.master      m,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned TOTAL = H_PIXELS * V_LINES;
  localparam int FETCH_W = $clog2(TOTAL + 1);
  localparam int X_W     = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int Y_W     = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int OCC_W   = $clog2(SKID_DEPTH + RD_LATENCY + 1);

  state_t                  state;
  logic [FETCH_W-1:0]      fetch_cnt;
  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic [RD_LATENCY-1:0]   inflight;
  logic [SKID_CNT_W-1:0]   skid_cnt;
  logic [DATA_W-1:0]       skid_dout;
  logic [OCC_W-1:0]        occupancy;
  logic                    push;
  logic                    pop;
  logic                    valid;
  logic                    last_x;
  logic                    last_y;
  logic                    eof_hs;

  // Oldest outstanding request has its data on rddata this cycle.
  assign push = inflight[RD_LATENCY-1];

  always_comb begin
    occupancy = OCC_W'(skid_cnt);
    for (int i = 0; i < RD_LATENCY; i++) begin
      occupancy = occupancy + OCC_W'(inflight[i]);
    end
  end

  assign rd_req = (state == ST_RUN) && !rfifo_empty &&
                  (fetch_cnt < FETCH_W'(TOTAL)) &&
                  (occupancy < OCC_W'(SKID_DEPTH));

  ddr3_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk   (rd_clk),
    .rst   (rd_clk_sync_rst),
    .push  (push),
    .din   (rddata),
    .pop   (pop),
    .dout  (skid_dout),
    .count (skid_cnt)
  );

  assign valid  = (skid_cnt != '0);
  assign pop    = valid && m.m_ready;
  assign last_x = (x == X_W'(H_PIXELS - 1));
  assign last_y = (y == Y_W'(V_LINES - 1));
  assign eof_hs = pop && last_x && last_y;

  assign m.m_valid = valid;
  assign m.m_data  = skid_dout;
  assign m.m_sof   = valid && (x == '0) && (y == '0);
  assign m.m_eol   = valid && last_x;
  assign m.m_eof   = valid && last_x && last_y;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge rd_clk) begin
    if (rd_clk_sync_rst) begin
      state      <= ST_IDLE;
      fetch_cnt  <= '0;
      x          <= '0;
      y          <= '0;
      inflight   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      inflight   <= RD_LATENCY'({inflight, rd_req});
      if (rd_req) begin
        fetch_cnt <= fetch_cnt + 1'b1;
      end
      if (pop) begin
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            state     <= ST_RUN;
            fetch_cnt <= '0;
            x         <= '0;
            y         <= '0;
          end
        end
        ST_RUN: begin
          if (fetch_cnt == FETCH_W'(TOTAL)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (eof_hs) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_rd_stream.sv
// Directed bench for ddr3_rd_stream on a 4x2 frame with a behavioural read FIFO.
module tb_ddr3_rd_stream;

  localparam int DATA_W = 16;
  localparam int H      = 4;
  localparam int V      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_start;
  logic              rfifo_empty;
  logic [DATA_W-1:0] rddata;
  logic              rd_req;
  logic              busy;
  logic              frame_done;

  ddr3_rd_stream_if #(.DATA_W(DATA_W)) s_if ();

  ddr3_rd_stream #(.DATA_W(DATA_W), .H_PIXELS(H), .V_LINES(V)) dut (
    .rd_clk          (clk),
    .rd_clk_sync_rst (rst),
    .rd_start        (rd_start),
    .rfifo_empty     (rfifo_empty),
    .rddata          (rddata),
    .rd_req          (rd_req),
    .m               (s_if),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc;
  int req_count;
  int req_while_empty;
  int done_count;
  int done_cyc;
  logic [63:0] req_mask;
  logic [63:0] valid_mask;
  logic [63:0] busy_mask;
  logic [6:0]  outs;
  logic [15:0] data_s;
  logic [15:0] next_word;
  logic [15:0] got_data [$];
  logic [2:0]  got_mark [$];
  int          got_cyc  [$];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test(input logic [15:0] base);
    cyc             = 0;
    req_count       = 0;
    req_while_empty = 0;
    done_count      = 0;
    done_cyc        = -1;
    req_mask        = '0;
    valid_mask      = '0;
    busy_mask       = '0;
    next_word       = base;
    got_data.delete();
    got_mark.delete();
    got_cyc.delete();
  endtask

  // Drives one cycle of inputs, samples outputs mid-cycle, then models the FIFO pop.
  task automatic apply_stimulus(input logic r, input logic start, input logic empty, input logic ready);
    logic s_req;
    rst          = r;
    rd_start     = start;
    rfifo_empty  = empty;
    s_if.m_ready = ready;
    @(negedge clk);
    s_req  = rd_req;
    outs   = {rd_req, s_if.m_valid, s_if.m_sof, s_if.m_eol, s_if.m_eof, busy, frame_done};
    data_s = s_if.m_data;
    if (rd_req) req_count++;
    if (rd_req && rfifo_empty) req_while_empty++;
    if (cyc < 64) begin
      req_mask[cyc]   = rd_req;
      valid_mask[cyc] = s_if.m_valid;
      busy_mask[cyc]  = busy;
    end
    if (s_if.m_valid && s_if.m_ready) begin
      got_data.push_back(s_if.m_data);
      got_mark.push_back({s_if.m_sof, s_if.m_eol, s_if.m_eof});
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_count++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (s_req) begin
      rddata    = next_word;
      next_word = next_word + 16'd1;
    end
    cyc++;
  endtask

  task automatic check_frame(input string tag, input int first, input logic [15:0] base);
    logic [2:0] em;
    for (int i = 0; i < H * V; i++) begin
      em = {(i == 0), ((i % H) == H - 1), (i == H * V - 1)};
      check_output($sformatf("%s_data%0d", tag, i), 64'(got_data[first + i]), 64'(base + 16'(i)));
      check_output($sformatf("%s_mark%0d", tag, i), 64'(got_mark[first + i]), 64'(em));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b1;
    rd_start     = 1'b0;
    rfifo_empty  = 1'b1;
    s_if.m_ready = 1'b0;
    rddata       = '0;
    start_test(16'h0);
    @(posedge clk);
    #1;

    // Reset held with random inputs: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      rddata = 16'($urandom);
      apply_stimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      check_output($sformatf("rst_outs%0d", i), 64'(outs), 64'h0);
      check_output($sformatf("rst_data%0d", i), 64'(data_s), 64'h0);
    end
    apply_stimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    check_output("post_rst_outs", 64'(outs), 64'h0);
    check_output("post_rst_data", 64'(data_s), 64'h0);

    // Small frame, no stalls.
    start_test(16'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 14; c++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("nostall_req_mask", req_mask, 64'h1FE);
    check_output("nostall_valid_mask", valid_mask, 64'h7F8);
    check_output("nostall_busy_mask", busy_mask, 64'h7FE);
    check_output("nostall_done_cyc", 64'(done_cyc), 64'd11);
    check_output("nostall_done_count", 64'(done_count), 64'd1);
    check_output("nostall_words", 64'(got_data.size()), 64'd8);
    check_output("nostall_first_cyc", 64'(got_cyc[0]), 64'd3);
    check_frame("nostall", 0, 16'h0);

    // Backpressure: only four requests until the sink accepts.
    start_test(16'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 16; c++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("bp_req_mask", req_mask, 64'h1E);
    check_output("bp_stall_valid", 64'(outs[5]), 64'd1);
    for (int c = 16; c < 46; c++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("bp_req_count", 64'(req_count), 64'd8);
    check_output("bp_words", 64'(got_data.size()), 64'd8);
    check_output("bp_done_count", 64'(done_count), 64'd1);
    check_frame("bp", 0, 16'h0);

    // Read FIFO empty toggling every three cycles.
    start_test(16'h0);
    for (int c = 0; c < 60; c++) apply_stimulus(1'b0, c == 0, ((c / 3) % 2) == 0, 1'b1);
    check_output("empty_req_while_empty", 64'(req_while_empty), 64'd0);
    check_output("empty_req_count", 64'(req_count), 64'd8);
    check_output("empty_words", 64'(got_data.size()), 64'd8);
    check_output("empty_done_count", 64'(done_count), 64'd1);
    check_frame("empty", 0, 16'h0);

    // Start pulse during a running frame is dropped.
    start_test(16'h0);
    for (int c = 0; c < 25; c++) apply_stimulus(1'b0, (c == 0) || (c == 4), 1'b0, 1'b1);
    check_output("ign_req_count", 64'(req_count), 64'd8);
    check_output("ign_done_count", 64'(done_count), 64'd1);
    check_output("ign_busy_end", 64'(outs[1]), 64'd0);

    // Back-to-back: start coincident with frame_done.
    start_test(16'h0);
    for (int c = 0; c < 26; c++) apply_stimulus(1'b0, (c == 0) || (c == 11), 1'b0, 1'b1);
    check_output("b2b_req_count", 64'(req_count), 64'd16);
    check_output("b2b_done_count", 64'(done_count), 64'd2);
    check_output("b2b_done_cyc", 64'(done_cyc), 64'd22);
    check_output("b2b_words", 64'(got_data.size()), 64'd16);
    check_output("b2b_second_sof_cyc", 64'(got_cyc[8]), 64'd14);
    check_frame("b2b2", 8, 16'h8);

    // Mid-frame reset, then a clean restart from x=0, y=0.
    start_test(16'h0);
    for (int c = 0; c < 5; c++) apply_stimulus(1'b0, c == 0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("midrst_outs", 64'(outs), 64'h0);
    check_output("midrst_data", 64'(data_s), 64'h0);
    start_test(16'h40);
    for (int c = 0; c < 20; c++) apply_stimulus(1'b0, c == 0, 1'b0, 1'b1);
    check_output("restart_words", 64'(got_data.size()), 64'd8);
    check_output("restart_done_count", 64'(done_count), 64'd1);
    check_frame("restart", 0, 16'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
